// File: rtl/pdm_decimator.sv
// ============================================================================
//  Module      : pdm_decimator
//  Description : 3rd-order CIC decimator turning a 1-bit PDM stream into
//                unsigned 16-bit PCM, one output per 2**LOG2_R input bits.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pdm_decimator #(
    parameter int LOG2_R = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        din,
    output logic [15:0] pcm,
    output logic        pcm_valid,
    output logic        settled
);

    localparam int ACC_W = 3 * LOG2_R + 1;

    localparam logic [LOG2_R-1:0] c_CNT_MAX = '1;
    localparam logic [ACC_W-1:0]  c_FULL    = {1'b1, {(3 * LOG2_R){1'b0}}};

    logic [ACC_W-1:0]  r_i1;
    logic [ACC_W-1:0]  r_i2;
    logic [ACC_W-1:0]  r_i3;
    logic [ACC_W-1:0]  r_i3_d;
    logic [ACC_W-1:0]  r_c1_d;
    logic [ACC_W-1:0]  r_c2_d;
    logic [LOG2_R-1:0] r_cnt;
    logic              r_tick_d;
    logic [15:0]       r_pcm;
    logic              r_pcm_valid;
    logic [2:0]        r_vcnt;

    logic              w_tick;
    logic [ACC_W-1:0]  w_c1;
    logic [ACC_W-1:0]  w_c2;
    logic [ACC_W-1:0]  w_c3;
    logic [ACC_W-1:0]  w_sat;
    logic              w_unused_bits;

    assign w_tick = en && (r_cnt == c_CNT_MAX);

    // Comb chain is fully combinational; only the delay taps are registered.
    assign w_c1  = r_i3 - r_i3_d;
    assign w_c2  = w_c1 - r_c1_d;
    assign w_c3  = w_c2 - r_c2_d;
    assign w_sat = (w_c3 == c_FULL) ? (c_FULL - 1'b1) : w_c3;

    assign w_unused_bits = ^{w_sat[ACC_W-1], w_sat[ACC_W-18:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_i1  <= '0;
            r_i2  <= '0;
            r_i3  <= '0;
            r_cnt <= '0;
        end else if (en) begin
            r_i1  <= r_i1 + {{(ACC_W-1){1'b0}}, din};
            r_i2  <= r_i2 + r_i1;
            r_i3  <= r_i3 + r_i2;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // The comb update runs the clock after a tick, independent of en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tick_d    <= 1'b0;
            r_i3_d      <= '0;
            r_c1_d      <= '0;
            r_c2_d      <= '0;
            r_pcm       <= 16'h0000;
            r_pcm_valid <= 1'b0;
        end else begin
            r_tick_d    <= w_tick;
            r_pcm_valid <= r_tick_d;
            if (r_tick_d) begin
                r_i3_d <= r_i3;
                r_c1_d <= w_c1;
                r_c2_d <= w_c2;
                r_pcm  <= w_sat[ACC_W-2 -: 16];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vcnt <= 3'd0;
        end else if (r_tick_d && (r_vcnt != 3'd7)) begin
            r_vcnt <= r_vcnt + 3'd1;
        end
    end

    assign pcm       = r_pcm;
    assign pcm_valid = r_pcm_valid;
    assign settled   = r_vcnt[2];

endmodule

`default_nettype wire

// File: tb/tb_pdm_decimator.sv
// ============================================================================
//  Module      : tb_pdm_decimator
//  Description : Directed self-checking bench for pdm_decimator (R = 64).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pdm_decimator;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        din;
    logic [15:0] pcm;
    logic        pcm_valid;
    logic        settled;

    int tests = 0;
    int fails = 0;

    // Stimulus generator state: pattern 0=zeros 1=ones 2=1,0 3=1,0,0,0
    int pat_mode = 0;
    int en_div   = 0;
    int en_ph    = 0;
    int din_ph   = 0;

    pdm_decimator #(.LOG2_R(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .din       (din),
        .pcm       (pcm),
        .pcm_valid (pcm_valid),
        .settled   (settled)
    );

    always #5 clk = ~clk;

    task automatic set_mode(input int mode, input int div);
        pat_mode = mode;
        en_div   = div;
        en_ph    = 0;
        din_ph   = 0;
    endtask

    // Drive one cycle of stimulus, then sample just after the next edge.
    task automatic step();
        logic b;
        if (en_div == 0) begin
            en = 1'b0;
        end else begin
            en    = (en_ph == 0);
            en_ph = (en_ph + 1) % en_div;
        end
        case (pat_mode)
            1:       b = 1'b1;
            2:       b = ((din_ph % 2) == 0);
            3:       b = ((din_ph % 4) == 0);
            default: b = 1'b0;
        endcase
        din = b;
        if (en) din_ph++;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pulse(input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!pcm_valid && n < budget);
        if (!pcm_valid) begin
            tests++;
            fails++;
            $display("FAIL pulse_timeout: no pcm_valid within %0d clk", budget);
        end
    endtask

    task automatic skip_pulses(input int count, input int budget);
        int n;
        for (int k = 0; k < count; k++) wait_pulse(budget, n);
    endtask

    task automatic test_reset();
        int pulses;
        set_mode(2, 1);
        rst    = 1'b0;
        pulses = 0;
        repeat (192) begin
            step();
            if (pcm_valid) pulses++;
        end
        tests++;
        if (pcm !== 16'h0000) begin
            fails++; $display("FAIL reset_pcm: got %h want 0000", pcm);
        end
        tests++;
        if (pcm_valid !== 1'b0) begin
            fails++; $display("FAIL reset_valid: got %b want 0", pcm_valid);
        end
        tests++;
        if (settled !== 1'b0) begin
            fails++; $display("FAIL reset_settled: got %b want 0", settled);
        end
        tests++;
        if (pulses !== 0) begin
            fails++; $display("FAIL reset_pulses: got %0d want 0", pulses);
        end
        rst = 1'b1;
        set_mode(2, 0);
        pulses = 0;
        repeat (192) begin
            step();
            if (pcm_valid) pulses++;
        end
        tests++;
        if (pulses !== 0) begin
            fails++; $display("FAIL release_idle_pulses: got %0d want 0", pulses);
        end
    endtask

    task automatic test_ones();
        int n;
        set_mode(1, 1);
        wait_pulse(400, n);
        // 64th en bit lands on edge 64; pcm_valid registers on edge 65
        tests++;
        if (n !== 65) begin
            fails++; $display("FAIL first_latency: got %0d clk want 65", n);
        end
        tests++;
        if (settled !== 1'b0) begin
            fails++; $display("FAIL settled_p1: got %b want 0", settled);
        end
        for (int k = 2; k <= 7; k++) begin
            wait_pulse(400, n);
            tests++;
            if (n !== 64) begin
                fails++; $display("FAIL ones_interval p%0d: got %0d want 64", k, n);
            end
            if (k == 3) begin
                tests++;
                if (settled !== 1'b0) begin
                    fails++; $display("FAIL settled_p3: got %b want 0", settled);
                end
            end
            if (k >= 4) begin
                tests++;
                if (settled !== 1'b1) begin
                    fails++; $display("FAIL settled_p%0d: got %b want 1", k, settled);
                end
                tests++;
                if (pcm !== 16'hFFFF) begin
                    fails++; $display("FAIL ones_pcm p%0d: got %h want FFFF", k, pcm);
                end
            end
        end
    endtask

    task automatic test_level(input int mode, input logic [15:0] exp);
        int n;
        set_mode(mode, 1);
        skip_pulses(4, 400);
        for (int k = 0; k < 3; k++) begin
            wait_pulse(400, n);
            tests++;
            if (pcm !== exp || settled !== 1'b1) begin
                fails++;
                $display("FAIL level_mode%0d: pcm %h settled %b want %h settled 1",
                         mode, pcm, settled, exp);
            end
        end
    endtask

    task automatic test_en_duty();
        int n;
        int pulses;
        set_mode(1, 3);
        skip_pulses(4, 800);
        for (int k = 0; k < 3; k++) begin
            wait_pulse(800, n);
            tests++;
            if (n !== 192) begin
                fails++; $display("FAIL duty_interval: got %0d want 192", n);
            end
            tests++;
            if (pcm !== 16'hFFFF) begin
                fails++; $display("FAIL duty_pcm: got %h want FFFF", pcm);
            end
        end
        set_mode(1, 0);
        pulses = 0;
        repeat (1000) begin
            step();
            if (pcm_valid) pulses++;
        end
        tests++;
        if (pulses !== 0) begin
            fails++; $display("FAIL hold_pulses: got %0d want 0", pulses);
        end
        tests++;
        if (pcm !== 16'hFFFF) begin
            fails++; $display("FAIL hold_pcm: got %h want FFFF", pcm);
        end
    endtask

    // Long d=1/2 run: i2/i3 wrap modulo 2**19 many times over.
    task automatic test_wrap();
        int n;
        set_mode(2, 1);
        skip_pulses(4, 400);
        for (int k = 0; k < 64; k++) begin
            wait_pulse(400, n);
            tests++;
            if (pcm !== 16'h8000 || n !== 64) begin
                fails++;
                $display("FAIL wrap_p%0d: pcm %h interval %0d want 8000 / 64", k, pcm, n);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        repeat (20) step();
        #3;
        rst = 1'b0;
        #1;
        tests++;
        if (settled !== 1'b0 || pcm !== 16'h0000 || pcm_valid !== 1'b0) begin
            fails++;
            $display("FAIL midreset_async: settled %b pcm %h valid %b want 0/0000/0",
                     settled, pcm, pcm_valid);
        end
        repeat (5) step();
        rst = 1'b1;
        set_mode(2, 1);
        wait_pulse(400, n);
        tests++;
        if (n !== 65) begin
            fails++; $display("FAIL midreset_latency: got %0d want 65", n);
        end
        for (int k = 2; k <= 5; k++) begin
            wait_pulse(400, n);
            tests++;
            if (settled !== (k >= 4)) begin
                fails++; $display("FAIL midreset_settled p%0d: got %b want %b", k, settled, (k >= 4));
            end
            if (k >= 4) begin
                tests++;
                if (pcm !== 16'h8000) begin
                    fails++; $display("FAIL midreset_pcm p%0d: got %h want 8000", k, pcm);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        en  = 1'b0;
        din = 1'b0;
        test_reset();
        test_ones();
        test_level(0, 16'h0000);
        test_level(2, 16'h8000);
        test_level(3, 16'h4000);
        test_en_duty();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
